lcd_ctrl: RTL

HD44780-compatible character-LCD controller that sits between the CPU's LCD I/O register and the DE2 LCD pins. The CPU no longer bit-bangs the LCD pins: it hands over one command or data byte per valid/ready handshake. The block generates the bus timing (setup, enable pulse, hold) and the controller execution wait. After reset it runs the mandatory power-up initialisation sequence on its own. The interface is write-only: RW is held low and the busy flag is never read; timing is met by fixed waits.

---
 rtl/lcd_pkg.sv | 56 +++++
 rtl/lcd_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD controller: FSM state
// encoding, HD44780 command bytes and the power-up initialisation ROM.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_PWRUP = 3'd0;
  localparam lcd_state_t ST_SETUP = 3'd1;
  localparam lcd_state_t ST_PULSE = 3'd2;
  localparam lcd_state_t ST_HOLD  = 3'd3;
  localparam lcd_state_t ST_EXEC  = 3'd4;
  localparam lcd_state_t ST_IDLE  = 3'd5;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  // Which execution wait follows a write.
  typedef enum logic [1:0] {
    WAIT_EXEC,
    WAIT_CLEAR,
    WAIT_INIT1,
    WAIT_INIT2
  } wait_sel_e;

  typedef struct packed {
    logic [7:0] cmd;
    wait_sel_e  wsel;
  } init_step_t;

  localparam int         INIT_STEPS = 6;
  localparam logic [2:0] INIT_LAST  = 3'(INIT_STEPS - 1);

  function automatic init_step_t init_rom(input logic [2:0] idx);
    init_step_t s;
    case (idx)
      3'd0:    s = '{cmd: LCD_FUNC_SET, wsel: WAIT_INIT1};
      3'd1:    s = '{cmd: LCD_FUNC_SET, wsel: WAIT_INIT2};
      3'd2:    s = '{cmd: LCD_FUNC_SET, wsel: WAIT_EXEC};
      3'd3:    s = '{cmd: LCD_DISP_ON,  wsel: WAIT_EXEC};
      3'd4:    s = '{cmd: LCD_CLEAR,    wsel: WAIT_CLEAR};
      default: s = '{cmd: LCD_ENTRY,    wsel: WAIT_EXEC};
    endcase
    return s;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long wait.
  function automatic wait_sel_e req_wait_sel(input logic rs, input logic [7:0] data);
    wait_sel_e w;
    if (!rs && (data >= 8'h01) && (data <= 8'h03)) w = WAIT_CLEAR;
    else                                             w = WAIT_EXEC;
    return w;
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus controller: runs the power-up init sequence, then
// turns each accepted CPU byte into a timed setup/enable/hold/exec cycle.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLEAR_CYC = 82000,
  parameter int T_INIT1_CYC = 205000,
  parameter int T_INIT2_CYC = 5000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(
    max_of(max_of(POWERUP_CYC, T_SETUP_CYC), max_of(T_EN_CYC, T_HOLD_CYC)),
    max_of(max_of(T_EXEC_CYC, T_CLEAR_CYC), max_of(T_INIT1_CYC, T_INIT2_CYC)));
  localparam int TMR_W = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  function automatic logic [TMR_W-1:0] wait_cycles(input wait_sel_e w);
    logic [TMR_W-1:0] c;
    case (w)
      WAIT_CLEAR: c = TMR_W'(T_CLEAR_CYC);
      WAIT_INIT1: c = TMR_W'(T_INIT1_CYC);
      WAIT_INIT2: c = TMR_W'(T_INIT2_CYC);
      default:    c = TMR_W'(T_EXEC_CYC);
    endcase
    return c;
  endfunction

  lcd_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             on_q, on_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic       tmr_last;
  logic [2:0] rom_idx;
  init_step_t rom_step;

  // One ROM port: the current step while picking its wait, the next step otherwise.
  always_comb begin
    rom_idx = idx_q + 3'd1;
    if (state_q == ST_PWRUP)     rom_idx = 3'd0;
    else if (state_q == ST_HOLD) rom_idx = idx_q;
  end

  assign rom_step = init_rom(rom_idx);
  assign tmr_last = (tmr_q <= TMR_ONE);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    done_d  = done_q;
    on_d    = 1'b1;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;

    case (state_q)
      ST_PWRUP: begin
        if (tmr_last) begin
          state_d = ST_SETUP;
          tmr_d   = TMR_W'(T_SETUP_CYC);
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = rom_step.cmd;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_SETUP: begin
        if (tmr_last) begin
          state_d = ST_PULSE;
          tmr_d   = TMR_W'(T_EN_CYC);
          en_d    = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_PULSE: begin
        if (tmr_last) begin
          state_d = ST_HOLD;
          tmr_d   = TMR_W'(T_HOLD_CYC);
          en_d    = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_HOLD: begin
        if (tmr_last) begin
          state_d = ST_EXEC;
          tmr_d   = done_q ? wait_cycles(req_wait_sel(rs_q, data_q))
                           : wait_cycles(rom_step.wsel);
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_EXEC: begin
        if (tmr_last) begin
          if (!done_q && (idx_q != INIT_LAST)) begin
            state_d = ST_SETUP;
            tmr_d   = TMR_W'(T_SETUP_CYC);
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            data_d  = rom_step.cmd;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_IDLE: begin
        if (req_valid_i && done_q) begin
          state_d = ST_SETUP;
          tmr_d   = TMR_W'(T_SETUP_CYC);
          rs_d    = req_rs_i;
          data_d  = req_data_i;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        tmr_d   = TMR_W'(POWERUP_CYC);
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_PWRUP;
      tmr_q   <= TMR_W'(POWERUP_CYC);
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      on_q    <= on_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && done_q;
  assign init_done_o = done_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;

endmodule
